hazard_detection_unit: RTL and testbench
========================================

Name:
hazard_detection_unit

Overview:
- Hazard unit for the 5-stage RISC-V pipeline; sits beside the IF/ID and ID/EX pipeline registers.
- Detects load-use data hazards and stalls the front end while injecting a bubble into EX.
- Requests an IF flush on a taken BEQ.
- Hazard decisions are combinational; a clocked section keeps saturating stall/flush event counters for debug and performance visibility.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; counters update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_RegisterRs1  in  5  rs1 of the instruction in ID.
- IF_ID_RegisterRs2  in  5  rs2 of the instruction in ID.
- ID_EX_RegisterRd  in  5  rd of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- IF_ID_MemWrite  in  1  instruction in ID is a store.
- zero  in  1  branch comparison equal.
- beq  in  1  instruction in ID is a BEQ.
- PCWrite  out  1  1 = PC may update; 0 = hold PC.
- IF_ID_Write  out  1  1 = IF/ID register may load; 0 = hold.
- ControlMuxSel  out  1  1 = zero all control signals into ID/EX (bubble); 0 = pass decoded control.
- IF_Flush  out  1  1 = squash the instruction being fetched (IF/ID gets a NOP).
- stall_count  out  CNT_W  number of cycles with a stall asserted.
- flush_count  out  CNT_W  number of cycles with a flush asserted.

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low.
- rd_hit1 = (ID_EX_RegisterRd == IF_ID_RegisterRs1).
- rd_hit2 = (ID_EX_RegisterRd == IF_ID_RegisterRs2) && !IF_ID_MemWrite. Store data on rs2 is forwarded in MEM, so a store does not stall on rs2.
- stall = ID_EX_MemRead && (ID_EX_RegisterRd != 0) && (rd_hit1 || rd_hit2). An rd of x0 never stalls.
- take = beq && zero.
- Stall outputs:
  - stall=1 -> PCWrite=0, IF_ID_Write=0, ControlMuxSel=1.
  - stall=0 -> PCWrite=1, IF_ID_Write=1, ControlMuxSel=0.
- IF_Flush = take && !stall.
  - Stall has priority: branch operands are not valid while a load-use hazard is pending. The branch re-evaluates the next cycle.
- All four hazard outputs are purely combinational with zero-cycle latency. They are not gated by clk.
- While rst_n=0, hazard outputs are forced to the passive state: PCWrite=1, IF_ID_Write=1, ControlMuxSel=0, IF_Flush=0.
- Counters:
  - rst_n=0 clears stall_count and flush_count to 0 immediately (asynchronous).
  - Each rising clk edge: stall_count += 1 if stall; flush_count += 1 if IF_Flush.
  - Both counters saturate at all-ones (2^CNT_W - 1) with no wrap.
- Reset deasserted mid-hazard: outputs reflect inputs combinationally at once. Counting starts at the first rising edge after release.
- X/Z on inputs is not handled specially.

Decomposition:
- Shared pipeline package holds REG_ADDR_W=5 and the constant REG_X0=5'd0.
- Recommended sub-module: hdu_sat_counter (parameterised width, async active-low clear, enable, saturating), instantiated twice.
- The hazard logic itself stays flat in the top module.

Test Plan:
- No hazard: rs1=1, rs2=2, rd=3, MemRead=0, beq=0 -> PCWrite=1, IF_ID_Write=1, ControlMuxSel=0, IF_Flush=0; counters hold.
- Taken branch: same operands, beq=1, zero=1 -> IF_Flush=1, PCWrite=1; flush_count increments once per clock edge held.
- Load-use: rs1=1, rs2=2, rd=1, MemRead=1, MemWrite=0 -> PCWrite=0, IF_ID_Write=0, ControlMuxSel=1; stall_count increments.
- Load-use plus taken branch together: rd=1 matching rs1, beq=1, zero=1 -> stall outputs asserted, IF_Flush=0.
- Edge cases:
  - rs1=6, rs2=5, rd=6, MemRead=0 -> no stall.
  - rd=0, MemRead=1 -> no stall.
  - rd=rs2=5, MemWrite=1, rs1≠5 -> no stall.
- Reset and saturation:
  - Assert rst_n=0 mid-stall -> counters read 0 without a clock edge; outputs passive.
  - With CNT_W=2 and a stall held 5 cycles -> stall_count=3.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_pkg
// Description : Shared pipeline constants for the hazard detection unit:
//               register-address width and the hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_detection_unit_pkg;

    localparam int                  REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0   = 5'd0;

endpackage : hazard_detection_unit_pkg
`default_nettype wire

// File: rtl/hazard_detection_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_if
// Description : Bundle of pipeline-register fields examined by the hazard
//               unit and the stall/flush controls it returns.
//               master : pipeline side (drives fields, receives controls)
//               slave  : hazard unit  (reads fields, drives controls)
//   IF_ID_RegisterRs1/Rs2 : source registers of the instruction in ID
//   ID_EX_RegisterRd      : destination register of the instruction in EX
//   ID_EX_MemRead         : EX instruction is a load
//   IF_ID_MemWrite        : ID instruction is a store
//   zero / beq            : branch compare result / ID instruction is BEQ
//   PCWrite, IF_ID_Write  : 1 = allow update, 0 = hold
//   ControlMuxSel         : 1 = bubble into ID/EX
//   IF_Flush              : 1 = squash the fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_detection_unit_if;
    import hazard_detection_unit_pkg::*;

    logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1;
    logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2;
    logic [REG_ADDR_W-1:0] ID_EX_RegisterRd;
    logic                  ID_EX_MemRead;
    logic                  IF_ID_MemWrite;
    logic                  zero;
    logic                  beq;
    logic                  PCWrite;
    logic                  IF_ID_Write;
    logic                  ControlMuxSel;
    logic                  IF_Flush;

    modport master (
        output IF_ID_RegisterRs1, IF_ID_RegisterRs2, ID_EX_RegisterRd,
               ID_EX_MemRead, IF_ID_MemWrite, zero, beq,
        input  PCWrite, IF_ID_Write, ControlMuxSel, IF_Flush
    );

    modport slave (
        input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, ID_EX_RegisterRd,
               ID_EX_MemRead, IF_ID_MemWrite, zero, beq,
        output PCWrite, IF_ID_Write, ControlMuxSel, IF_Flush
    );

endinterface : hazard_detection_unit_if
`default_nettype wire

// File: rtl/hdu_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hdu_sat_counter
// Description : Event counter with asynchronous active-low clear. Counts one
//               per rising edge while enabled and sticks at all-ones.
//   clk     : count clock
//   rst_n   : asynchronous active-low clear
//   en_i    : count this cycle
//   count_o : current count
// Revision    : 1.0 - initial release
// ============================================================================
module hdu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en_i,
    output logic [WIDTH-1:0]      count_o
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // Hold at the maximum instead of wrapping so a long-running counter never
    // reports a misleadingly small value.
    always_comb begin
        w_count_d = r_count_q;
        if (en_i && (r_count_q != c_MAX)) begin
            w_count_d = r_count_q + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count_o = r_count_q;

endmodule : hdu_sat_counter
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Load-use stall and taken-BEQ flush control for the 5-stage
//               pipeline, plus saturating stall/flush event counters.
//   clk         : pipeline clock (counters only)
//   rst_n       : asynchronous active-low reset
//   hz          : pipeline fields in, stall/flush controls out
//   stall_count : cycles with a stall asserted (saturating)
//   flush_count : cycles with a flush asserted (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    hazard_detection_unit_if.slave hz,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    logic w_rd_hit1;
    logic w_rd_hit2;
    logic w_load_use;
    logic w_take;
    logic w_stall;
    logic w_flush;

    // A store consumes rs2 only as write data, which is forwarded in MEM,
    // so an rs2 match on a store is not a hazard.
    assign w_rd_hit1  = (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs1);
    assign w_rd_hit2  = (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs2) && !hz.IF_ID_MemWrite;
    assign w_load_use = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRd != REG_X0)
                        && (w_rd_hit1 || w_rd_hit2);
    assign w_take     = hz.beq && hz.zero;

    // Reset forces the passive state. A pending load-use suppresses the flush
    // because the branch operands are stale; the branch re-resolves next cycle.
    assign w_stall = rst_n && w_load_use;
    assign w_flush = rst_n && w_take && !w_load_use;

    assign hz.PCWrite       = !w_stall;
    assign hz.IF_ID_Write   = !w_stall;
    assign hz.ControlMuxSel = w_stall;
    assign hz.IF_Flush      = w_flush;

    hdu_sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_stall),
        .count_o (stall_count)
    );

    hdu_sat_counter #(
        .WIDTH   (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_flush),
        .count_o (flush_count)
    );

endmodule : hazard_detection_unit
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Self-checking bench for hazard_detection_unit. Two instances
//               share stimulus: default CNT_W=16 and CNT_W=2 for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

    typedef struct {
        logic pcw;
        logic ifw;
        logic cms;
        logic fl;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] t_rs1, t_rs2, t_rd;
    logic       t_mr, t_mw, t_zero, t_beq;

    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    exp_t        exp_q[$];
    logic        m_stall, m_flush;
    logic [15:0] m_sc_a, m_fc_a;
    logic [1:0]  m_sc_b, m_fc_b;

    int tests;
    int fails;

    hazard_detection_unit_if if_a ();
    hazard_detection_unit_if if_b ();

    assign if_a.IF_ID_RegisterRs1 = t_rs1;
    assign if_a.IF_ID_RegisterRs2 = t_rs2;
    assign if_a.ID_EX_RegisterRd  = t_rd;
    assign if_a.ID_EX_MemRead     = t_mr;
    assign if_a.IF_ID_MemWrite    = t_mw;
    assign if_a.zero              = t_zero;
    assign if_a.beq               = t_beq;
    assign if_b.IF_ID_RegisterRs1 = t_rs1;
    assign if_b.IF_ID_RegisterRs2 = t_rs2;
    assign if_b.ID_EX_RegisterRd  = t_rd;
    assign if_b.ID_EX_MemRead     = t_mr;
    assign if_b.IF_ID_MemWrite    = t_mw;
    assign if_b.zero              = t_zero;
    assign if_b.beq               = t_beq;

    hazard_detection_unit #(.CNT_W(16)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (if_a),
        .stall_count (stall_cnt_a),
        .flush_count (flush_cnt_a)
    );

    hazard_detection_unit #(.CNT_W(2)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (if_b),
        .stall_count (stall_cnt_b),
        .flush_count (flush_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Recompute the model from the current input vars and reset, and push the
    // expected combinational outputs.
    task automatic model_push();
        logic h1, h2, lu, tk;
        exp_t e;
        h1 = (t_rd == t_rs1);
        h2 = (t_rd == t_rs2) && !t_mw;
        lu = t_mr && (t_rd != 5'd0) && (h1 || h2);
        tk = t_beq && t_zero;
        m_stall = rst_n && lu;
        m_flush = rst_n && tk && !lu;
        e.pcw = !m_stall;
        e.ifw = !m_stall;
        e.cms = m_stall;
        e.fl  = m_flush;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic z, input logic b);
        t_rs1 = rs1; t_rs2 = rs2; t_rd = rd;
        t_mr = mr; t_mw = mw; t_zero = z; t_beq = b;
        model_push();
    endtask

    task automatic check_out(input string name);
        exp_t e;
        #1;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, no expected value", name);
        end else begin
            e = exp_q.pop_front();
            if ({if_a.PCWrite, if_a.IF_ID_Write, if_a.ControlMuxSel, if_a.IF_Flush}
                !== {e.pcw, e.ifw, e.cms, e.fl}) begin
                fails++;
                $display("FAIL %s (A): got pcw/ifw/cms/fl=%b%b%b%b expected %b%b%b%b", name,
                         if_a.PCWrite, if_a.IF_ID_Write, if_a.ControlMuxSel, if_a.IF_Flush,
                         e.pcw, e.ifw, e.cms, e.fl);
            end
            tests++;
            if ({if_b.PCWrite, if_b.IF_ID_Write, if_b.ControlMuxSel, if_b.IF_Flush}
                !== {e.pcw, e.ifw, e.cms, e.fl}) begin
                fails++;
                $display("FAIL %s (B): got pcw/ifw/cms/fl=%b%b%b%b expected %b%b%b%b", name,
                         if_b.PCWrite, if_b.IF_ID_Write, if_b.ControlMuxSel, if_b.IF_Flush,
                         e.pcw, e.ifw, e.cms, e.fl);
            end
        end
    endtask

    task automatic check_counts(input string name);
        tests++;
        if (stall_cnt_a !== m_sc_a || flush_cnt_a !== m_fc_a) begin
            fails++;
            $display("FAIL %s cnt16: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, stall_cnt_a, flush_cnt_a, m_sc_a, m_fc_a);
        end
        tests++;
        if (stall_cnt_b !== m_sc_b || flush_cnt_b !== m_fc_b) begin
            fails++;
            $display("FAIL %s cnt2: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, stall_cnt_b, flush_cnt_b, m_sc_b, m_fc_b);
        end
    endtask

    // Advance one rising edge, update the counter model, check counters 1 ns later.
    task automatic clk_step(input string name);
        @(posedge clk);
        if (rst_n) begin
            if (m_stall) begin
                if (m_sc_a != 16'hFFFF) m_sc_a = m_sc_a + 16'd1;
                if (m_sc_b != 2'b11)    m_sc_b = m_sc_b + 2'd1;
            end
            if (m_flush) begin
                if (m_fc_a != 16'hFFFF) m_fc_a = m_fc_a + 16'd1;
                if (m_fc_b != 2'b11)    m_fc_b = m_fc_b + 2'd1;
            end
        end
        #1;
        check_counts(name);
    endtask

    task automatic test_reset();
        // Load-use inputs while in reset: outputs must still be passive.
        drive(5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_out("reset_outputs_passive");
        check_counts("reset_counts_zero");
        clk_step("reset_edge_no_count");
        #2;
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("post_reset_idle");
    endtask

    task automatic test_no_hazard();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("no_hazard");
        for (int i = 0; i < 2; i++) clk_step("no_hazard_hold");
    endtask

    task automatic test_taken_branch();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        check_out("taken_branch");
        for (int i = 0; i < 3; i++) clk_step("taken_branch_count");
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("beq_not_taken");
        clk_step("beq_not_taken_count");
    endtask

    task automatic test_load_use();
        drive(5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("load_use_rs1");
        clk_step("load_use_rs1_count");
        drive(5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("load_use_rs2");
        clk_step("load_use_rs2_count");
    endtask

    task automatic test_stall_priority();
        drive(5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_out("stall_over_flush");
        clk_step("stall_over_flush_count");
    endtask

    task automatic test_edge_cases();
        drive(5'd6, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("match_no_memread");
        clk_step("match_no_memread_count");
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("rd_x0_no_stall");
        clk_step("rd_x0_count");
        drive(5'd7, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("store_rs2_no_stall");
        drive(5'd5, 5'd8, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("store_rs1_stalls");
        clk_step("store_rs1_count");
    endtask

    task automatic test_saturation();
        drive(5'd3, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("sat_stall_drive");
        for (int i = 0; i < 5; i++) clk_step("sat_stall_hold");
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        check_out("sat_flush_drive");
        for (int i = 0; i < 5; i++) clk_step("sat_flush_hold");
    endtask

    task automatic test_reset_mid_stall();
        drive(5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("pre_reset_stall");
        clk_step("pre_reset_stall_count");
        #2;
        rst_n = 1'b0;
        m_sc_a = '0; m_fc_a = '0; m_sc_b = '0; m_fc_b = '0;
        model_push();
        check_out("mid_stall_reset_passive");
        check_counts("mid_stall_reset_async_clear");
        #2;
        rst_n = 1'b1;
        model_push();
        check_out("release_mid_hazard");
        check_counts("release_no_count_yet");
        clk_step("first_edge_after_release");
    endtask

    task automatic test_back_to_back();
        drive(5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("b2b_stall");
        clk_step("b2b_stall_count");
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        check_out("b2b_flush");
        clk_step("b2b_flush_count");
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("b2b_idle");
        clk_step("b2b_idle_count");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        m_sc_a = '0; m_fc_a = '0; m_sc_b = '0; m_fc_b = '0;
        m_stall = 1'b0; m_flush = 1'b0;
        t_rs1 = '0; t_rs2 = '0; t_rd = '0;
        t_mr = 1'b0; t_mw = 1'b0; t_zero = 1'b0; t_beq = 1'b0;
        #2;
        test_reset();
        test_no_hazard();
        test_taken_branch();
        test_load_use();
        test_stall_priority();
        test_edge_cases();
        test_saturation();
        test_reset_mid_stall();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_detection_unit
`default_nettype wire
